la_cmd_link: RTL and testbench
==============================

# la_cmd_link

Command/response link layer for the logic analyzer's host port. It parses command frames from the UART's received-byte stream and applies writes to a small bank of 8-bit configuration registers. It then drives the UART's byte-transmit interface to send a response frame for every complete command. It sits between the UART core and the capture/trigger logic, which consumes the `cfg_regs` outputs.

## Interface
- `NREG`, 8: number of 8-bit configuration registers (1..16).
- `TIMEOUT`, 200000: maximum clock cycles allowed between bytes inside a frame.
- `VERSION`, 8'h01: data byte returned by PING.
- `clk`  in  1  master clock.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high.
- `rx_byte`  in  8  byte from UART, valid when `received`=1.
- `received`  in  1  one-cycle strobe, new byte.
- `recv_error`  in  1  one-cycle strobe, UART framing error.
- `transmit`  out  1  one-cycle request to UART to send `tx_byte`.
- `tx_byte`  out  8  byte to send.
- `is_transmitting`  in  1  UART TX busy.
- `rts`  in  1  host ready to accept bytes; a new byte is only started while high.
- `busy`  out  1  high from frame accept until the last response byte completes; feeds UART `busy` to drop `cts`.
- `cfg_regs`  out  NREG*8  register bank, reg k at `[8k+7:8k]`.
- `err_count`  out  8  saturating count of dropped or bad frames.

## Operation
- Command frame: `A5`, CMD, ADDR, DATA, CHK. CHK = CMD^ADDR^DATA.
- Response frame: `5A`, STATUS, DATA, CHK. CHK = STATUS^DATA.
- CMD `01` WRITE: reg[ADDR] <= DATA; response DATA = new value.
- CMD `02` READ: DATA ignored; response DATA = reg[ADDR]. ADDR `FF` returns `err_count`.
- CMD `03` PING: response DATA = `VERSION`.
- STATUS `00` ok; `E1` unknown CMD; `E2` ADDR >= NREG (except READ `FF`); `E3` CHK mismatch. Non-zero status: response DATA = `00`, no register write.
- An `E1`/`E2`/`E3` status also increments `err_count`. The counter saturates at `FF`.
- Parser states: P_SYNC, P_CMD, P_ADDR, P_DATA, P_CHK, P_EXEC, P_RESP.
  - In P_SYNC, bytes other than `A5` are discarded silently.
  - P_CMD..P_CHK advance on each `received`.
  - P_EXEC lasts 1 cycle.
  - P_RESP returns to P_SYNC after byte 4 completes.
- Sender per byte:
  - Wait for `rts`=1 and `is_transmitting`=0.
  - Pulse `transmit` for one cycle, with `tx_byte` held stable.
  - Wait for `is_transmitting`=1, then for `is_transmitting`=0.
  - Move to the next byte.
- `received` while in P_EXEC/P_RESP: byte is ignored, no error counted.
- `recv_error` in P_CMD..P_CHK: frame dropped, `err_count`++, go to P_SYNC. In P_SYNC: ignored.
- Inter-byte timeout:
  - A counter clears on every `received`.
  - In P_CMD..P_CHK, reaching `TIMEOUT` drops the frame, increments `err_count`, returns to P_SYNC, and sends no response.
- Simultaneous `received` and timeout in the same cycle: the byte wins and the timeout is discarded.

## Timing
- Reset values:
  - `transmit`=0, `tx_byte`=00, `busy`=0.
  - `cfg_regs` all 0, `err_count`=0.
  - Parser in P_SYNC, sender idle.
- Reset mid-frame or mid-response aborts immediately. A UART byte already in flight completes on its own.
- CHK byte `received` at cycle N:
  - `busy`=1 and P_EXEC at N+1.
  - `cfg_regs` updated at N+1 (visible N+2).
  - First `transmit` pulse at N+2 if `rts`=1 and the UART is idle.
- `busy` falls the cycle after `is_transmitting` falls for byte 4.
- `rts` low only delays the start of the next byte. It never cuts off a byte in progress.

## Configuration
- `LA_CMD_CHECKSUM_EN` defined:
  - Frames are 5 bytes in and 4 bytes out, as above.
  - STATUS `E3` is possible.
- Not defined:
  - The P_CHK state is removed; the command is 4 bytes (`A5`, CMD, ADDR, DATA), and P_EXEC follows DATA.
  - The response is 3 bytes (`5A`, STATUS, DATA).
  - `E3` is never produced.
  - Latency is the same, measured from the DATA byte.

## Test plan
- Send `A5 01 02 3C 3F` -> `cfg_regs[23:16]`=`3C` at N+2; response `5A 00 3C 3C`; `busy` high throughout.
- Send `A5 02 02 00 00` after the previous write -> response `5A 00 3C 3C`. Then send `A5 03 00 00 03` -> `5A 00 01 01`.
- Send `A5 01 09 11 19` (NREG=8) -> response `5A E2 00 E2`, no register change, `err_count`=1. Send `A5 01 02 3C 00` -> `5A E3 00 E3`, `err_count`=2.
- Send `A5 01`, then silence for `TIMEOUT` cycles -> no response, `err_count`++. Then `A5 02 FF 00 FD` -> response DATA = `err_count`.
- Hold `rts`=0 during a response -> no `transmit` while low. Release after 1000 cycles -> remaining bytes are sent in order, with no duplicates.
- Assert `rst` mid-response, then release -> all outputs at reset values. The next valid frame is handled normally.

Source files
------------

// File: rtl/la_cmd_link.sv
// la_cmd_link - command/response link layer for the logic analyzer host port.
//
// Parses command frames from the UART receive strobe stream, executes
// WRITE / READ / PING against a small bank of 8-bit configuration registers,
// and sends one response frame per complete command over the UART transmit
// handshake.
//
//   Command  : A5, CMD, ADDR, DATA [, CHK]   CHK    = CMD ^ ADDR ^ DATA
//   Response : 5A, STATUS, DATA [, CHK]      CHK    = STATUS ^ DATA
//   STATUS   : 00 ok, E1 unknown CMD, E2 bad ADDR, E3 checksum mismatch
//
// Build option: define LA_CMD_CHECKSUM_EN to carry the trailing CHK byte in
// both directions (5-byte commands, 4-byte responses, E3 possible). Without
// it, commands are 4 bytes, responses 3 bytes and E3 is never produced.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rx_byte/received  received byte and its one-cycle strobe
//   recv_error        one-cycle UART framing-error strobe
//   transmit/tx_byte  one-cycle send request and the byte to send
//   is_transmitting   UART transmitter busy
//   rts               host ready; a new byte only starts while high
//   busy              high from frame accept until the last response byte ends
//   cfg_regs          register bank, reg k at [8k+7:8k]
//   err_count         saturating count of dropped or rejected frames
module la_cmd_link #(
  parameter int          NREG    = 8,
  parameter int          TIMEOUT = 200000,
  parameter logic [7:0]  VERSION = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              received,
  input  logic              recv_error,
  output logic              transmit,
  output logic [7:0]        tx_byte,
  input  logic              is_transmitting,
  input  logic              rts,
  output logic              busy,
  output logic [NREG*8-1:0] cfg_regs,
  output logic [7:0]        err_count
);

  localparam logic [7:0] SYNC_IN    = 8'hA5;
  localparam logic [7:0] SYNC_OUT   = 8'h5A;
  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_PING   = 8'h03;
  localparam logic [7:0] ADDR_ERRC  = 8'hFF;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BADCMD  = 8'hE1;
  localparam logic [7:0] ST_BADADDR = 8'hE2;
`ifdef LA_CMD_CHECKSUM_EN
  localparam logic [7:0] ST_BADCHK  = 8'hE3;
  localparam int         NRESP      = 4;
`else
  localparam int         NRESP      = 3;
`endif
  localparam int         TW         = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    P_SYNC,
    P_CMD,
    P_ADDR,
    P_DATA,
`ifdef LA_CMD_CHECKSUM_EN
    P_CHK,
`endif
    P_EXEC,
    P_RESP
  } pstate_t;

  // Per-byte transmit handshake inside P_RESP.
  typedef enum logic [1:0] {
    S_START,    // wait for rts=1 and UART idle, then pulse transmit
    S_WAIT_HI,  // wait for the UART to pick the byte up
    S_WAIT_LO   // wait for the UART to finish the byte
  } sstate_t;

  pstate_t           p_q, p_d;
  sstate_t           s_q, s_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        status_q, status_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [7:0]        err_q, err_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NREG*8-1:0] regs_q, regs_d;
`ifdef LA_CMD_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic       in_frame;
  logic       timeout_hit;
  logic       chk_ok;
  logic       addr_ok;
  logic [7:0] rd_reg;
  logic [7:0] ex_status;
  logic [7:0] ex_data;
  logic       ex_wr;
  logic [7:0] resp_byte;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef LA_CMD_CHECKSUM_EN
  assign in_frame = (p_q == P_CMD) || (p_q == P_ADDR) || (p_q == P_DATA) ||
                    (p_q == P_CHK);
  assign chk_ok   = (chk_q == (cmd_q ^ addr_q ^ data_q));
`else
  assign in_frame = (p_q == P_CMD) || (p_q == P_ADDR) || (p_q == P_DATA);
  assign chk_ok   = 1'b1;
`endif

  assign addr_ok = ({1'b0, addr_q} < 9'(NREG));

  // A byte arriving in the same cycle as the timeout wins, so the timeout
  // only fires on a cycle without a received strobe.
  assign timeout_hit = in_frame && !received && (timer_q == TW'(TIMEOUT - 1));

  // Command execution result, consumed during the single P_EXEC cycle.
  always_comb begin
    ex_status = ST_OK;
    ex_data   = 8'h00;
    ex_wr     = 1'b0;
    rd_reg    = 8'h00;
    for (int k = 0; k < NREG; k++) begin
      if (addr_q == 8'(k)) rd_reg = regs_q[8*k +: 8];
    end
    // A corrupt frame cannot be trusted for CMD/ADDR, so E3 takes priority.
    if (!chk_ok) begin
`ifdef LA_CMD_CHECKSUM_EN
      ex_status = ST_BADCHK;
`endif
    end else begin
      case (cmd_q)
        CMD_WRITE: begin
          if (addr_ok) begin
            ex_wr   = 1'b1;
            ex_data = data_q;
          end else begin
            ex_status = ST_BADADDR;
          end
        end
        CMD_READ: begin
          if (addr_q == ADDR_ERRC)  ex_data   = err_q;
          else if (addr_ok)         ex_data   = rd_reg;
          else                      ex_status = ST_BADADDR;
        end
        CMD_PING: ex_data = VERSION;
        default:  ex_status = ST_BADCMD;
      endcase
    end
  end

  // Response byte selected by the sender's byte index.
  always_comb begin
    case (idx_q)
      2'd0:    resp_byte = SYNC_OUT;
      2'd1:    resp_byte = status_q;
      2'd2:    resp_byte = rdata_q;
      default: resp_byte = status_q ^ rdata_q;
    endcase
  end

  assign tx_byte   = (p_q == P_RESP) ? resp_byte : 8'h00;
  assign busy      = (p_q == P_EXEC) || (p_q == P_RESP);
  assign cfg_regs  = regs_q;
  assign err_count = err_q;

  // Parser and sender next-state logic.
  always_comb begin
    p_d      = p_q;
    s_d      = s_q;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    data_d   = data_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    regs_d   = regs_q;
    transmit = 1'b0;
`ifdef LA_CMD_CHECKSUM_EN
    chk_d    = chk_q;
`endif

    if (received || !in_frame) timer_d = '0;
    else                       timer_d = timer_q + TW'(1);

    if (in_frame && (recv_error || timeout_hit)) begin
      p_d   = P_SYNC;
      err_d = sat_inc(err_q);
    end else begin
      case (p_q)
        P_SYNC: begin
          if (received && (rx_byte == SYNC_IN)) p_d = P_CMD;
        end
        P_CMD: begin
          if (received) begin
            cmd_d = rx_byte;
            p_d   = P_ADDR;
          end
        end
        P_ADDR: begin
          if (received) begin
            addr_d = rx_byte;
            p_d    = P_DATA;
          end
        end
        P_DATA: begin
          if (received) begin
            data_d = rx_byte;
`ifdef LA_CMD_CHECKSUM_EN
            p_d    = P_CHK;
`else
            p_d    = P_EXEC;
`endif
          end
        end
`ifdef LA_CMD_CHECKSUM_EN
        P_CHK: begin
          if (received) begin
            chk_d = rx_byte;
            p_d   = P_EXEC;
          end
        end
`endif
        P_EXEC: begin
          status_d = ex_status;
          rdata_d  = ex_data;
          if (ex_status != ST_OK) err_d = sat_inc(err_q);
          if (ex_wr) begin
            for (int k = 0; k < NREG; k++) begin
              if (addr_q == 8'(k)) regs_d[8*k +: 8] = data_q;
            end
          end
          idx_d = 2'd0;
          s_d   = S_START;
          p_d   = P_RESP;
        end
        P_RESP: begin
          case (s_q)
            S_START: begin
              if (rts && !is_transmitting) begin
                transmit = 1'b1;
                s_d      = S_WAIT_HI;
              end
            end
            S_WAIT_HI: begin
              if (is_transmitting) s_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
              if (!is_transmitting) begin
                s_d = S_START;
                if (idx_q == 2'(NRESP - 1)) p_d   = P_SYNC;
                else                        idx_d = idx_q + 2'd1;
              end
            end
            default: s_d = S_START;
          endcase
        end
        default: p_d = P_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q      <= P_SYNC;
      s_q      <= S_START;
      idx_q    <= 2'd0;
      cmd_q    <= 8'h00;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      status_q <= 8'h00;
      rdata_q  <= 8'h00;
      err_q    <= 8'h00;
      timer_q  <= '0;
      regs_q   <= '0;
`ifdef LA_CMD_CHECKSUM_EN
      chk_q    <= 8'h00;
`endif
    end else begin
      p_q      <= p_d;
      s_q      <= s_d;
      idx_q    <= idx_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      regs_q   <= regs_d;
`ifdef LA_CMD_CHECKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_la_cmd_link.sv
// Self-checking bench for la_cmd_link: a UART transmit model captures every
// byte the DUT sends, and a register/error-count model built from the frame
// rules predicts each response.
module tb_la_cmd_link;

  localparam int         NREG    = 8;
  localparam int         TIMEOUT = 64;
  localparam logic [7:0] VERSION = 8'h01;
`ifdef LA_CMD_CHECKSUM_EN
  localparam int         NRESP   = 4;
`else
  localparam int         NRESP   = 3;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_byte;
  logic              received;
  logic              recv_error;
  logic              transmit;
  logic [7:0]        tx_byte;
  logic              is_transmitting;
  logic              rts;
  logic              busy;
  logic [NREG*8-1:0] cfg_regs;
  logic [7:0]        err_count;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  logic [7:0] cap[$];
  logic [7:0] m_regs[NREG];
  logic [7:0] m_err;

  la_cmd_link #(.NREG(NREG), .TIMEOUT(TIMEOUT), .VERSION(VERSION)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .received(received),
    .recv_error(recv_error), .transmit(transmit), .tx_byte(tx_byte),
    .is_transmitting(is_transmitting), .rts(rts), .busy(busy),
    .cfg_regs(cfg_regs), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // UART transmitter: accepts a transmit pulse, then stays busy for a while.
  initial begin
    is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (transmit === 1'b1) begin
        cap.push_back(tx_byte);
        @(posedge clk); #1 is_transmitting = 1'b1;
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1 is_transmitting = 1'b0;
      end
    end
  end

  // A transmit pulse is never legal while the host is not ready or the UART busy.
  initial begin
    forever begin
      @(negedge clk);
      if (transmit === 1'b1 && (rts !== 1'b1 || is_transmitting !== 1'b0)) viol++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_byte = b; received = 1'b1;
    tick(1);
    received = 1'b0; rx_byte = 8'($urandom);
    tick(gap);
  endtask

  // Returns one cycle after the last command byte was strobed.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] chk);
    send_byte(8'hA5, $urandom_range(0, 3));
    send_byte(cmd,   $urandom_range(0, 3));
    send_byte(addr,  $urandom_range(0, 3));
`ifdef LA_CMD_CHECKSUM_EN
    send_byte(data,  $urandom_range(0, 3));
    send_byte(chk,   0);
`else
    send_byte(data,  0);
    if (chk == 8'h00) tick(0);
`endif
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && is_transmitting === 1'b0) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pack_cap();
    logic [31:0] w = 32'h0;
    for (int i = 0; i < cap.size() && i < 4; i++) w[31-8*i -: 8] = cap[i];
    return w;
  endfunction

  function automatic logic [31:0] exp_word(input logic [7:0] st, input logic [7:0] dat);
`ifdef LA_CMD_CHECKSUM_EN
    return {8'h5A, st, dat, st ^ dat};
`else
    return {8'h5A, st, dat, 8'h00};
`endif
  endfunction

  function automatic logic [NREG*8-1:0] model_bank();
    logic [NREG*8-1:0] v;
    for (int k = 0; k < NREG; k++) v[8*k +: 8] = m_regs[k];
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;
    m_err = 8'h00;
  endfunction

  function automatic void model_bump_err();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endfunction

  // Reference behaviour of one complete command; returns the expected frame.
  function automatic logic [31:0] model_cmd(input logic [7:0] cmd, input logic [7:0] addr,
                                            input logic [7:0] data, input logic [7:0] chk);
    logic [7:0] st = 8'h00;
    logic [7:0] dat = 8'h00;
    bit bad_chk = 1'b0;
`ifdef LA_CMD_CHECKSUM_EN
    bad_chk = (chk != (cmd ^ addr ^ data));
`else
    bad_chk = (chk != chk);
`endif
    if (bad_chk) st = 8'hE3;
    else if (cmd == 8'h01) begin
      if (addr < NREG) begin m_regs[addr] = data; dat = data; end else st = 8'hE2;
    end else if (cmd == 8'h02) begin
      if (addr == 8'hFF) dat = m_err;
      else if (addr < NREG) dat = m_regs[addr];
      else st = 8'hE2;
    end else if (cmd == 8'h03) dat = VERSION;
    else st = 8'hE1;
    if (st != 8'h00) model_bump_err();
    return exp_word(st, (st == 8'h00) ? dat : 8'h00);
  endfunction

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                           input logic [7:0] chk, output logic [31:0] got, output int n,
                           output bit ok);
    cap.delete();
    send_frame(cmd, addr, data, chk);
    wait_idle(3000, ok);
    got = pack_cap();
    n = cap.size();
  endtask

  task automatic test_reset();
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit got %b want 0", transmit); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (cfg_regs !== '0) begin errors++; $display("FAIL reset_cfg got %h want 0", cfg_regs); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err got %h want 00", err_count); end
  endtask

  task automatic test_write();
    logic [31:0] exp; bit ok;
    cap.delete();
    exp = model_cmd(8'h01, 8'h02, 8'h3C, 8'h3F);
    send_frame(8'h01, 8'h02, 8'h3C, 8'h3F);
    @(negedge clk);  // cycle N+1
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_n1 got %b want 1", busy); end
    checks++; if (cfg_regs[23:16] !== 8'h00) begin errors++; $display("FAIL write_reg_n1 got %h want 00", cfg_regs[23:16]); end
    @(negedge clk);  // cycle N+2
    checks++; if (cfg_regs[23:16] !== 8'h3C) begin errors++; $display("FAIL write_reg_n2 got %h want 3c", cfg_regs[23:16]); end
    checks++; if (transmit !== 1'b1 || tx_byte !== 8'h5A) begin errors++; $display("FAIL write_first_tx got %b/%h want 1/5a", transmit, tx_byte); end
    @(posedge clk); #1;
    wait_idle(3000, ok);
    checks++; if (!ok || cap.size() != NRESP || pack_cap() !== exp) begin
      errors++; $display("FAIL write_resp got %h (n=%0d ok=%0d) want %h", pack_cap(), cap.size(), ok, exp); end
  endtask

  task automatic test_read_ping();
    logic [31:0] got, exp; int n; bit ok;
    exp = model_cmd(8'h02, 8'h02, 8'h00, 8'h00);
    run_frame(8'h02, 8'h02, 8'h00, 8'h00, got, n, ok);
    checks++; if (!ok || n != NRESP || got !== exp) begin errors++; $display("FAIL read_resp got %h n=%0d want %h", got, n, exp); end
    exp = model_cmd(8'h03, 8'h00, 8'h00, 8'h03);
    run_frame(8'h03, 8'h00, 8'h00, 8'h03, got, n, ok);
    checks++; if (!ok || n != NRESP || got !== exp) begin errors++; $display("FAIL ping_resp got %h n=%0d want %h", got, n, exp); end
  endtask

  task automatic test_errors();
    logic [31:0] got, exp; int n; bit ok;
    exp = model_cmd(8'h01, 8'h09, 8'h11, 8'h19);
    run_frame(8'h01, 8'h09, 8'h11, 8'h19, got, n, ok);
    checks++; if (!ok || n != NRESP || got !== exp) begin errors++; $display("FAIL bad_addr_resp got %h n=%0d want %h", got, n, exp); end
    checks++; if (err_count !== m_err || cfg_regs !== model_bank()) begin errors++; $display("FAIL bad_addr_state got %h/%h want %h/%h", err_count, cfg_regs, m_err, model_bank()); end
`ifdef LA_CMD_CHECKSUM_EN
    exp = model_cmd(8'h01, 8'h02, 8'h3C, 8'h00);
    run_frame(8'h01, 8'h02, 8'h3C, 8'h00, got, n, ok);
    checks++; if (!ok || n != NRESP || got !== exp) begin errors++; $display("FAIL bad_chk_resp got %h n=%0d want %h", got, n, exp); end
`endif
    exp = model_cmd(8'h07, 8'h01, 8'h22, 8'h24);
    run_frame(8'h07, 8'h01, 8'h22, 8'h24, got, n, ok);
    checks++; if (!ok || n != NRESP || got !== exp) begin errors++; $display("FAIL bad_cmd_resp got %h n=%0d want %h", got, n, exp); end
    checks++; if (err_count !== m_err || cfg_regs !== model_bank()) begin errors++; $display("FAIL bad_cmd_state got %h/%h want %h/%h", err_count, cfg_regs, m_err, model_bank()); end
  endtask

  task automatic test_timeout();
    logic [31:0] got, exp; int n; bit ok;
    cap.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    tick(TIMEOUT + 10);
    model_bump_err();
    checks++; if (cap.size() != 0 || busy !== 1'b0 || err_count !== m_err) begin
      errors++; $display("FAIL timeout_drop got n=%0d busy=%b err=%h want 0/0/%h", cap.size(), busy, err_count, m_err); end
    // framing error mid-frame drops it; garbage and framing errors in sync are ignored
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h03, 1);
    recv_error = 1'b1; tick(1); recv_error = 1'b0; tick(2);
    model_bump_err();
    send_byte(8'h3C, 2); send_byte(8'h00, 2);
    recv_error = 1'b1; tick(1); recv_error = 1'b0; tick(2);
    checks++; if (cap.size() != 0 || err_count !== m_err || cfg_regs !== model_bank()) begin
      errors++; $display("FAIL recv_error_drop got n=%0d err=%h want 0/%h", cap.size(), err_count, m_err); end
    // a long but legal inter-byte gap keeps the frame alive
    cap.delete();
    exp = model_cmd(8'h01, 8'h04, 8'h5D, 8'h01 ^ 8'h04 ^ 8'h5D);
    send_byte(8'hA5, TIMEOUT - 10);
    send_byte(8'h01, TIMEOUT - 10);
    send_byte(8'h04, 1);
`ifdef LA_CMD_CHECKSUM_EN
    send_byte(8'h5D, 1);
    send_byte(8'h01 ^ 8'h04 ^ 8'h5D, 0);
`else
    send_byte(8'h5D, 0);
`endif
    wait_idle(3000, ok);
    checks++; if (!ok || cap.size() != NRESP || pack_cap() !== exp) begin errors++; $display("FAIL long_gap_resp got %h want %h", pack_cap(), exp); end
    exp = model_cmd(8'h02, 8'hFF, 8'h00, 8'hFD);
    run_frame(8'h02, 8'hFF, 8'h00, 8'hFD, got, n, ok);
    checks++; if (!ok || n != NRESP || got !== exp) begin errors++; $display("FAIL read_errcnt got %h n=%0d want %h", got, n, exp); end
  endtask

  task automatic test_rts();
    logic [31:0] exp; bit ok; bit seen = 1'b0;
    cap.delete();
    exp = model_cmd(8'h01, 8'h05, 8'h77, 8'h73);
    send_frame(8'h01, 8'h05, 8'h77, 8'h73);
    for (int i = 0; i < 300; i++) begin
      if (cap.size() >= 1) begin seen = 1'b1; break; end
      tick(1);
    end
    rts = 1'b0;
    tick(1000);
    checks++; if (!seen || cap.size() != 1 || busy !== 1'b1) begin
      errors++; $display("FAIL rts_hold got n=%0d busy=%b want 1/1", cap.size(), busy); end
    rts = 1'b1;
    wait_idle(3000, ok);
    checks++; if (!ok || cap.size() != NRESP || pack_cap() !== exp) begin
      errors++; $display("FAIL rts_release got %h n=%0d want %h", pack_cap(), cap.size(), exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp; int n; bit ok;
    cap.delete();
    exp = model_cmd(8'h02, 8'h05, 8'h00, 8'h07);
    send_frame(8'h02, 8'h05, 8'h00, 8'h07);
    for (int i = 0; i < 300 && cap.size() < 1; i++) tick(1);
    // bytes arriving while responding must be discarded
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h55, 0);
    wait_idle(3000, ok);
    tick(TIMEOUT + 20);
    checks++; if (!ok || cap.size() != NRESP || pack_cap() !== exp || cfg_regs !== model_bank() || err_count !== m_err) begin
      errors++; $display("FAIL ignore_during_resp got %h n=%0d want %h", pack_cap(), cap.size(), exp); end
    exp = model_cmd(8'h01, 8'h07, 8'hC3, 8'h01 ^ 8'h07 ^ 8'hC3);
    run_frame(8'h01, 8'h07, 8'hC3, 8'h01 ^ 8'h07 ^ 8'hC3, got, n, ok);
    checks++; if (!ok || n != NRESP || got !== exp || cfg_regs !== model_bank()) begin
      errors++; $display("FAIL b2b_write got %h n=%0d want %h", got, n, exp); end
  endtask

  task automatic test_random();
    logic [31:0] got, exp; int n; bit ok;
    logic [7:0] cmd, addr, data, chk, g;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: cmd = 8'h01; 1: cmd = 8'h02; 2: cmd = 8'h03; default: cmd = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0, 1: addr = 8'($urandom_range(0, NREG - 1));
        2: addr = 8'($urandom_range(NREG, NREG + 3));
        default: addr = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      endcase
      data = 8'($urandom);
      chk  = cmd ^ addr ^ data;
      if ($urandom_range(0, 4) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        g = 8'($urandom); if (g == 8'hA5) g = 8'h00;
        send_byte(g, $urandom_range(0, 2));
      end
      exp = model_cmd(cmd, addr, data, chk);
      run_frame(cmd, addr, data, chk, got, n, ok);
      checks++; if (!ok || n != NRESP || got !== exp || cfg_regs !== model_bank() || err_count !== m_err) begin
        errors++; $display("FAIL random_%0d cmd=%h addr=%h got %h/%h want %h/%h", it, cmd, addr, got, err_count, exp, m_err); end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] got, exp; int n; bit ok;
    for (int i = 0; i < 260; i++) begin
      exp = model_cmd(8'h01, 8'h20, 8'h00, 8'h21);
      run_frame(8'h01, 8'h20, 8'h00, 8'h21, got, n, ok);
    end
    checks++; if (err_count !== 8'hFF || m_err !== 8'hFF) begin errors++; $display("FAIL err_saturate got %h want ff", err_count); end
    exp = model_cmd(8'h02, 8'hFF, 8'h00, 8'hFD);
    run_frame(8'h02, 8'hFF, 8'h00, 8'hFD, got, n, ok);
    checks++; if (!ok || n != NRESP || got !== exp) begin errors++; $display("FAIL read_sat_errcnt got %h want %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp; int n; bit ok;
    cap.delete();
    send_frame(8'h01, 8'h01, 8'h99, 8'h01 ^ 8'h01 ^ 8'h99);
    for (int i = 0; i < 300 && cap.size() < 1; i++) tick(1);
    #2 rst = 1'b1;
    #1;
    checks++; if (transmit !== 1'b0 || tx_byte !== 8'h00 || busy !== 1'b0 || cfg_regs !== '0 || err_count !== 8'h00) begin
      errors++; $display("FAIL reset_mid got tx=%b byte=%h busy=%b err=%h want 0/00/0/00", transmit, tx_byte, busy, err_count); end
    tick(2);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 100 && is_transmitting; i++) tick(1);
    tick(2);
    checks++; if (busy !== 1'b0 || cap.size() != 1) begin errors++; $display("FAIL reset_abort got busy=%b n=%0d want 0/1", busy, cap.size()); end
    exp = model_cmd(8'h01, 8'h06, 8'hAB, 8'h01 ^ 8'h06 ^ 8'hAB);
    run_frame(8'h01, 8'h06, 8'hAB, 8'h01 ^ 8'h06 ^ 8'hAB, got, n, ok);
    checks++; if (!ok || n != NRESP || got !== exp || cfg_regs !== model_bank()) begin
      errors++; $display("FAIL after_reset got %h n=%0d want %h", got, n, exp); end
  endtask

  initial begin
    rst = 1'b1; rx_byte = 8'h00; received = 1'b0; recv_error = 1'b0; rts = 1'b1;
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(2);
    test_reset();
    test_write();
    test_read_ping();
    test_errors();
    test_timeout();
    test_rts();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_mid();
    checks++; if (viol != 0) begin errors++; $display("FAIL tx_protocol got %0d illegal pulses want 0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
